hazard_ctrl_ifid: RTL and testbench

//  Pipeline sequencing controller for the IF/ID buffer and the PC register. It

---
 rtl/hazard_ctrl_ifid_pkg.sv | 33 +++
 rtl/hazard_ctrl_ifid_sat_counter.sv | 23 ++
 rtl/hazard_ctrl_ifid.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl_ifid.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_ifid_pkg.sv
// Shared types and constants for the IF/ID hazard / sequencing controller.
package hazard_pkg;

    // Sequencing states of the front-end controller.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the remaining-cycles down-counter.
    localparam int REM_W = 16;

    // The five pipeline control outputs, bundled.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic if_flush;
        logic idex_bubble;
        logic freeze;
    } ctrl_t;

    // Output patterns, field order: pc_write, ifid_write, if_flush, idex_bubble, freeze.
    localparam ctrl_t CTRL_RUN   = 5'b11000;
    localparam ctrl_t CTRL_STALL = 5'b00010;
    localparam ctrl_t CTRL_FLUSH = 5'b10110;
    localparam ctrl_t CTRL_BUSY  = 5'b00001;
    localparam ctrl_t CTRL_RST   = 5'b00110;

endpackage

// File: rtl/hazard_ctrl_ifid_sat_counter.sv
// Saturating up-counter: stops at all-ones, never wraps.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, hold at all-ones; clear and reset return to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_ctrl_ifid.sv
// Front-end sequencing controller for the PC and IF/ID buffer: load-use
// stalls, taken-branch flushes, data-memory waits, and stall/flush counters.
//
// Handshake-style controls: pc_write and ifid_write are enables sampled by
// the PC and IF/ID registers on the same posedge; when if_flush=1 the IF/ID
// buffer loads a NOP and ifid_write is always 0 so the two never conflict.
module hazard_ctrl_ifid
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [REM_W-1:0] REM_ONE    = REM_W'(1);
    localparam logic [REM_W-1:0] LSTALL_REM = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] FLUSH_REM  = REM_W'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    ctrl_t             ctrl_fsm;
    ctrl_t             ctrl;
    logic              hazard;
    logic              stall_inc;
    logic              flush_inc;

    // Load-use dependency between the ID/EX load and the IF/ID consumer.
    always_comb begin
        hazard = idex_mem_read && (idex_rd != REG_X0) &&
                 ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    end

    // State and remaining-cycle register; reset aborts any stall or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and control outputs, highest-priority condition first.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ctrl_fsm = CTRL_RUN;
        if (mem_busy) begin
            // Whole pipe holds; sequencing state is frozen too.
            ctrl_fsm = CTRL_BUSY;
        end else if (ex_branch_taken) begin
            // Redirect wins over any pending load stall.
            ctrl_fsm = CTRL_FLUSH;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FLUSH_REM;
            end else begin
                state_d = RUN;
                rem_d   = '0;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    ctrl_fsm = CTRL_FLUSH;
                    rem_d    = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = RUN;
                    end
                end
                LSTALL: begin
                    ctrl_fsm = CTRL_STALL;
                    rem_d    = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (hazard) begin
                        ctrl_fsm = CTRL_STALL;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LSTALL;
                            rem_d   = LSTALL_REM;
                        end
                    end else begin
                        ctrl_fsm = CTRL_RUN;
                    end
                end
            endcase
        end
    end

    // Reset forces the safe pattern on the outputs immediately.
    always_comb begin
        ctrl = reset ? CTRL_RST : ctrl_fsm;
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign if_flush    = ctrl.if_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign freeze      = ctrl.freeze;

    // A stall cycle is one where IF/ID neither advances nor flushes.
    always_comb begin
        stall_inc = !ctrl_fsm.ifid_write && !ctrl_fsm.if_flush;
        flush_inc = ctrl_fsm.if_flush;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_ifid.sv
// Directed bench for hazard_ctrl_ifid. Two instances share the inputs:
// dut_a (1-cycle load stall, 2-cycle flush, 32-bit counters) and
// dut_b (3-cycle load stall, 2-cycle flush, 4-bit counters).
module tb_hazard_ctrl_ifid;

    // Control patterns: {pc_write, ifid_write, if_flush, idex_bubble, freeze}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b10110;
    localparam logic [4:0] O_BUSY  = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00110;

    logic        clk;
    logic        reset;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        ifid_uses_rs2;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic        ex_branch_taken;
    logic        mem_busy;

    logic        pc_write_a, ifid_write_a, if_flush_a, idex_bubble_a, freeze_a;
    logic [31:0] stall_cnt_a, flush_cnt_a;
    logic        pc_write_b, ifid_write_b, if_flush_b, idex_bubble_b, freeze_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    logic [4:0]  ctl_a, ctl_b;
    int          checks;
    int          failures;

    assign ctl_a = {pc_write_a, ifid_write_a, if_flush_a, idex_bubble_a, freeze_a};
    assign ctl_b = {pc_write_b, ifid_write_b, if_flush_b, idex_bubble_b, freeze_b};

    hazard_ctrl_ifid #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write_a), .ifid_write(ifid_write_a), .if_flush(if_flush_a),
        .idex_bubble(idex_bubble_a), .freeze(freeze_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl_ifid #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write_b), .ifid_write(ifid_write_b), .if_flush(if_flush_b),
        .idex_bubble(idex_bubble_b), .freeze(freeze_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        ifid_rs1        = 5'd0;
        ifid_rs2        = 5'd0;
        ifid_uses_rs2   = 1'b0;
        idex_mem_read   = 1'b0;
        idex_rd         = 5'd0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a posedge with reset released.
    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hazard_rs1(input logic [4:0] rd);
        idex_mem_read = 1'b1;
        idex_rd       = rd;
        ifid_rs1      = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        mem_busy = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ctl_a !== O_RST) begin failures++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, O_RST); end
        checks++; if (ctl_b !== O_RST) begin failures++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, O_RST); end
        checks++; if (stall_cnt_a !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt_a); end
        checks++; if (flush_cnt_a !== 32'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt_a); end
        apply_reset();
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL reset_release_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL reset_release_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        next_cycle();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_hazard_rs1(5'd5);
        @(negedge clk);
        checks++; if (ctl_a !== O_STALL) begin failures++; $display("FAIL lu_stall_ctl_a got=%b exp=%b", ctl_a, O_STALL); end
        checks++; if (stall_cnt_a !== 32'd0) begin failures++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt_a); end
        next_cycle();
        idex_mem_read = 1'b0;   // bubble now sits in ID/EX
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL lu_resume_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        checks++; if (stall_cnt_a !== 32'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt_a); end
        checks++; if (ctl_b !== O_STALL) begin failures++; $display("FAIL lu_lstall_ctl_b got=%b exp=%b", ctl_b, O_STALL); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl_b !== O_STALL) begin failures++; $display("FAIL lu_lstall3_ctl_b got=%b exp=%b", ctl_b, O_STALL); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL lu_lstall_end_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        checks++; if (stall_cnt_b !== 4'd3) begin failures++; $display("FAIL lu_stall_cnt_b got=%0d exp=3", stall_cnt_b); end
        next_cycle();
    endtask

    task automatic test_false_hazard();
        apply_reset();
        idex_mem_read = 1'b1;
        idex_rd       = 5'd0;
        ifid_rs1      = 5'd0;
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL fh_x0_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL fh_x0_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        next_cycle();
        idex_rd       = 5'd7;
        ifid_rs1      = 5'd3;
        ifid_rs2      = 5'd7;
        ifid_uses_rs2 = 1'b0;
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL fh_rs2_unused_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        next_cycle();
        idex_mem_read = 1'b0;
        ifid_uses_rs2 = 1'b1;
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL fh_not_load_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        next_cycle();
        idex_mem_read = 1'b1;
        @(negedge clk);
        checks++; if (ctl_a !== O_STALL) begin failures++; $display("FAIL fh_rs2_real_ctl_a got=%b exp=%b", ctl_a, O_STALL); end
        checks++; if (stall_cnt_a !== 32'd0) begin failures++; $display("FAIL fh_stall_cnt got=%0d exp=0", stall_cnt_a); end
        next_cycle();
    endtask

    task automatic test_branch();
        apply_reset();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (ctl_a !== O_FLUSH) begin failures++; $display("FAIL br_c1_ctl_a got=%b exp=%b", ctl_a, O_FLUSH); end
        next_cycle();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        checks++; if (ctl_a !== O_FLUSH) begin failures++; $display("FAIL br_c2_ctl_a got=%b exp=%b", ctl_a, O_FLUSH); end
        checks++; if (ctl_b !== O_FLUSH) begin failures++; $display("FAIL br_c2_ctl_b got=%b exp=%b", ctl_b, O_FLUSH); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL br_c3_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        checks++; if (flush_cnt_a !== 32'd2) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=2", flush_cnt_a); end
        checks++; if (stall_cnt_a !== 32'd0) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cnt_a); end
        next_cycle();
    endtask

    task automatic test_branch_vs_hazard();
        // Same-cycle branch and hazard.
        apply_reset();
        set_hazard_rs1(5'd9);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (ctl_b !== O_FLUSH) begin failures++; $display("FAIL bh_same_ctl_b got=%b exp=%b", ctl_b, O_FLUSH); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl_b !== O_FLUSH) begin failures++; $display("FAIL bh_same_c2_ctl_b got=%b exp=%b", ctl_b, O_FLUSH); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL bh_same_c3_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        checks++; if (stall_cnt_b !== 4'd0) begin failures++; $display("FAIL bh_same_stall_cnt got=%0d exp=0", stall_cnt_b); end
        // Branch in the 2nd cycle of a 3-cycle load stall.
        apply_reset();
        set_hazard_rs1(5'd9);
        @(negedge clk);
        checks++; if (ctl_b !== O_STALL) begin failures++; $display("FAIL bh_mid_c1_ctl_b got=%b exp=%b", ctl_b, O_STALL); end
        next_cycle();
        clear_inputs();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (ctl_b !== O_FLUSH) begin failures++; $display("FAIL bh_mid_c2_ctl_b got=%b exp=%b", ctl_b, O_FLUSH); end
        next_cycle();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        checks++; if (ctl_b !== O_FLUSH) begin failures++; $display("FAIL bh_mid_c3_ctl_b got=%b exp=%b", ctl_b, O_FLUSH); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL bh_mid_c4_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        checks++; if (stall_cnt_b !== 4'd1) begin failures++; $display("FAIL bh_mid_stall_cnt got=%0d exp=1", stall_cnt_b); end
        checks++; if (flush_cnt_b !== 4'd2) begin failures++; $display("FAIL bh_mid_flush_cnt got=%0d exp=2", flush_cnt_b); end
        next_cycle();
    endtask

    task automatic test_mem_busy();
        apply_reset();
        set_hazard_rs1(5'd12);
        @(negedge clk);
        checks++; if (ctl_b !== O_STALL) begin failures++; $display("FAIL mb_c1_ctl_b got=%b exp=%b", ctl_b, O_STALL); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl_b !== O_STALL) begin failures++; $display("FAIL mb_c2_ctl_b got=%b exp=%b", ctl_b, O_STALL); end
        next_cycle();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (ctl_b !== O_BUSY) begin failures++; $display("FAIL mb_busy%0d_ctl_b got=%b exp=%b", i, ctl_b, O_BUSY); end
            checks++; if (ctl_a !== O_BUSY) begin failures++; $display("FAIL mb_busy%0d_ctl_a got=%b exp=%b", i, ctl_a, O_BUSY); end
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        checks++; if (ctl_b !== O_STALL) begin failures++; $display("FAIL mb_resume_ctl_b got=%b exp=%b", ctl_b, O_STALL); end
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL mb_resume_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL mb_end_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        checks++; if (stall_cnt_b !== 4'd7) begin failures++; $display("FAIL mb_stall_cnt_b got=%0d exp=7", stall_cnt_b); end
        checks++; if (stall_cnt_a !== 32'd5) begin failures++; $display("FAIL mb_stall_cnt_a got=%0d exp=5", stall_cnt_a); end
        checks++; if (flush_cnt_b !== 4'd0) begin failures++; $display("FAIL mb_flush_cnt_b got=%0d exp=0", flush_cnt_b); end
        next_cycle();
    endtask

    task automatic test_reset_in_flush();
        apply_reset();
        ex_branch_taken = 1'b1;
        next_cycle();
        ex_branch_taken = 1'b0;   // now in FLUSH, flush_cnt_a = 1
        @(negedge clk);
        checks++; if (flush_cnt_a !== 32'd1) begin failures++; $display("FAIL rf_pre_flush_cnt got=%0d exp=1", flush_cnt_a); end
        #1 reset = 1'b1;
        #1;
        checks++; if (ctl_a !== O_RST) begin failures++; $display("FAIL rf_async_ctl_a got=%b exp=%b", ctl_a, O_RST); end
        checks++; if (flush_cnt_a !== 32'd0) begin failures++; $display("FAIL rf_async_flush_cnt got=%0d exp=0", flush_cnt_a); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (ctl_a !== O_RUN) begin failures++; $display("FAIL rf_release_ctl_a got=%b exp=%b", ctl_a, O_RUN); end
        checks++; if (ctl_b !== O_RUN) begin failures++; $display("FAIL rf_release_ctl_b got=%b exp=%b", ctl_b, O_RUN); end
        checks++; if (stall_cnt_a !== 32'd0) begin failures++; $display("FAIL rf_release_stall_cnt got=%0d exp=0", stall_cnt_a); end
        next_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        mem_busy = 1'b1;
        repeat (20) next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        checks++; if (stall_cnt_b !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt_b got=%0d exp=15", stall_cnt_b); end
        checks++; if (stall_cnt_a !== 32'd20) begin failures++; $display("FAIL sat_stall_cnt_a got=%0d exp=20", stall_cnt_a); end
        ex_branch_taken = 1'b1;
        repeat (20) next_cycle();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        checks++; if (flush_cnt_b !== 4'd15) begin failures++; $display("FAIL sat_flush_cnt_b got=%0d exp=15", flush_cnt_b); end
        checks++; if (flush_cnt_a !== 32'd20) begin failures++; $display("FAIL sat_flush_cnt_a got=%0d exp=20", flush_cnt_a); end
        checks++; if (stall_cnt_b !== 4'd15) begin failures++; $display("FAIL sat_stall_hold_b got=%0d exp=15", stall_cnt_b); end
        next_cycle();
    endtask

    // Test sequence and final report.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_false_hazard();
        test_branch();
        test_branch_vs_hazard();
        test_mem_busy();
        test_reset_in_flush();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
